// File: rtl/cnt_stream_checker.sv
// Receive-side checker for two free-running wrapping counter streams.
// Each channel locks onto its stream, then reports sequence breaks, wraps and lock loss.
//
// Channel FSM:
//   state    | meaning
//   S_SEARCH | hunting for LOCK_CNT consecutive correct increments; silent
//   S_LOCKED | tracking the sequence; reports errors and MAX->MIN wraps

module cnt_stream_checker_ch #(
  parameter int WIDTH    = 7,
  parameter int MIN      = 0,
  parameter int MAX      = 49,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 2,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] sample,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(LOSS_CNT + 1);
  localparam logic [WIDTH-1:0]  L_MIN  = WIDTH'(MIN);
  localparam logic [WIDTH-1:0]  L_MAX  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0]  L_SPAN = WIDTH'(MAX - MIN);
  localparam logic [RUN_W-1:0]  L_LOCK = RUN_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0] L_LOSS = MISS_W'(LOSS_CNT);

  typedef enum logic {
    S_SEARCH = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t             r_state,      w_state_nxt;
  logic [WIDTH-1:0]   r_prev,       w_prev_nxt;
  logic               r_prev_valid, w_prev_valid_nxt;
  logic [RUN_W-1:0]   r_run,        w_run_nxt;
  logic [MISS_W-1:0]  r_miss,       w_miss_nxt;
  logic               r_err,        w_err_nxt;
  logic               r_wrap,       w_wrap_nxt;
  logic [ERR_W-1:0]   r_err_cnt,    w_err_cnt_nxt;

  logic               w_in_range;
  logic               w_at_max;
  logic [WIDTH-1:0]   w_expected;
  logic               w_match;
  logic [RUN_W-1:0]   w_run_inc;
  logic [MISS_W-1:0]  w_miss_inc;
  logic [ERR_W-1:0]   w_err_cnt_inc;

  // Offset compare folds both bounds into one unsigned test (wraps below MIN).
  assign w_in_range    = (sample - L_MIN) <= L_SPAN;
  assign w_at_max      = (r_prev == L_MAX);
  assign w_expected    = w_at_max ? L_MIN : r_prev + WIDTH'(1);
  assign w_match       = r_prev_valid && w_in_range && (sample == w_expected);
  assign w_run_inc     = r_run + RUN_W'(1);
  assign w_miss_inc    = r_miss + MISS_W'(1);
  assign w_err_cnt_inc = (r_err_cnt == {ERR_W{1'b1}}) ? r_err_cnt : r_err_cnt + ERR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_SEARCH;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_run        <= '0;
      r_miss       <= '0;
      r_err        <= 1'b0;
      r_wrap       <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev       <= w_prev_nxt;
      r_prev_valid <= w_prev_valid_nxt;
      r_run        <= w_run_nxt;
      r_miss       <= w_miss_nxt;
      r_err        <= w_err_nxt;
      r_wrap       <= w_wrap_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_prev_nxt       = r_prev;
    w_prev_valid_nxt = r_prev_valid;
    w_run_nxt        = r_run;
    w_miss_nxt       = r_miss;
    w_err_nxt        = 1'b0;
    w_wrap_nxt       = 1'b0;
    w_err_cnt_nxt    = r_err_cnt;

    if (en) begin
      case (r_state)
        S_SEARCH: begin
          if (!w_in_range) begin
            w_prev_valid_nxt = 1'b0;
            w_run_nxt        = '0;
          end else if (!w_match) begin
            w_prev_nxt       = sample;
            w_prev_valid_nxt = 1'b1;
            w_run_nxt        = '0;
          end else begin
            w_prev_nxt = sample;
            w_run_nxt  = w_run_inc;
            if (w_run_inc == L_LOCK) begin
              w_state_nxt = S_LOCKED;
              w_miss_nxt  = '0;
            end
          end
        end
        S_LOCKED: begin
          if (w_match) begin
            w_prev_nxt = sample;
            w_miss_nxt = '0;
            w_wrap_nxt = w_at_max;
          end else begin
            // Resync onto the bad sample so a lone glitch costs two errors, not a run.
            w_err_nxt        = 1'b1;
            w_err_cnt_nxt    = w_err_cnt_inc;
            w_prev_nxt       = sample;
            w_prev_valid_nxt = w_in_range;
            w_miss_nxt       = w_miss_inc;
            if (w_miss_inc == L_LOSS) begin
              w_state_nxt = S_SEARCH;
              w_run_nxt   = '0;
            end
          end
        end
        default: w_state_nxt = S_SEARCH;
      endcase
    end
  end

  assign locked  = (r_state == S_LOCKED);
  assign err     = r_err;
  assign wrap    = r_wrap;
  assign err_cnt = r_err_cnt;

endmodule

module cnt_stream_checker #(
  parameter int WIDTH    = 7,
  parameter int A_MIN    = 0,
  parameter int A_MAX    = 49,
  parameter int B_MIN    = 50,
  parameter int B_MAX    = 99,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 2,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt_a,
  input  logic [WIDTH-1:0] cnt_b,
  output logic             locked_a,
  output logic             locked_b,
  output logic             err_a,
  output logic             err_b,
  output logic [ERR_W-1:0] err_cnt_a,
  output logic [ERR_W-1:0] err_cnt_b,
  output logic             wrap_a,
  output logic             wrap_b
);

  cnt_stream_checker_ch #(
    .WIDTH(WIDTH), .MIN(A_MIN), .MAX(A_MAX),
    .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(ERR_W)
  ) u_ch_a (
    .clk(clk), .rst_n(rst_n), .en(en), .sample(cnt_a),
    .locked(locked_a), .err(err_a), .wrap(wrap_a), .err_cnt(err_cnt_a)
  );

  cnt_stream_checker_ch #(
    .WIDTH(WIDTH), .MIN(B_MIN), .MAX(B_MAX),
    .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(ERR_W)
  ) u_ch_b (
    .clk(clk), .rst_n(rst_n), .en(en), .sample(cnt_b),
    .locked(locked_b), .err(err_b), .wrap(wrap_b), .err_cnt(err_cnt_b)
  );

endmodule
